lm_event_queue: RTL
===================

# lm_event_queue

Buffers event codes (UART data bytes, UART error codes, CM/VGA error codes) and presents them one at a time to the LED manager's decoder inputs. Each code stays on the LEDs for a fixed minimum visible time, followed by a blank gap, so that short or back-to-back events remain readable on the board. One instance sits directly upstream of each LED manager decoder input pair (code + valid).

## Interface
Parameters:
- WIDTH, 8: event code width in bits.
- DEPTH, 4: FIFO entries. Must be a power of 2 and ≥ 2.
- HOLD_CYCLES, 50_000_000: clock cycles each code is shown. Must be ≥ 1.
- GAP_CYCLES, 5_000_000: blank cycles after each code. 0 means no gap.

Ports. One clock; reset is asynchronous and active-high.
- clk, in, 1: system clock. All logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- wr_data, in, WIDTH: event code to enqueue.
- wr_en, in, 1: enqueue strobe. One push per high cycle.
- overflow_clr, in, 1: clears the sticky overflow flag.
- data_out, out, WIDTH: code currently displayed. Feeds the decoder's code input.
- data_valid, out, 1: high while data_out is being shown. Feeds the decoder's valid input.
- overflow, out, 1: sticky. Set when a push is dropped.
- level, out, $clog2(DEPTH)+1: number of entries currently in the FIFO. Excludes the displayed code.

## Operation
- The FIFO is circular, with wr_ptr and rd_ptr each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH. A separate counter holds the entry count.
- FSM states: IDLE, SHOW, GAP.
  - IDLE: if level > 0, pop the head into the display register, load the timer with HOLD_CYCLES-1, and go to SHOW. Otherwise stay in IDLE.
  - SHOW: data_valid = 1. Decrement the timer. At timer = 0:
    - if GAP_CYCLES > 0, load the timer with GAP_CYCLES-1 and go to GAP;
    - if GAP_CYCLES = 0, behave as IDLE in the same cycle: pop and reload SHOW if non-empty, else go to IDLE.
  - GAP: data_valid = 0 and data_out holds its last value. At timer = 0, behave as IDLE in the same cycle: pop and go to SHOW if non-empty, else go to IDLE.
- Timer width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, 2)).
- Push rules:
  - A push is accepted when level < DEPTH, or when a pop happens in the same cycle.
  - Otherwise the push is dropped, the FIFO is unchanged, and overflow is set.
- Simultaneous push and pop leaves level unchanged, and both pointers advance.
- Overflow flag:
  - overflow_clr clears overflow.
  - If overflow_clr and a drop occur in the same cycle, overflow stays set (set wins).
- A pop never occurs with level = 0, so there is no underflow.

## Timing
- Reset values:
  - FSM = IDLE, timer = 0, pointers = 0, level = 0.
  - data_out = 0, data_valid = 0, overflow = 0.
  - FIFO storage need not be reset.
- Reset takes effect immediately and asynchronously, including mid-SHOW or mid-GAP. data_valid drops without waiting for a clock edge, and all queued entries are discarded.
- Latency from an empty, idle block: wr_en at edge t, level = 1 after t, pop at t+1, data_valid = 1 after t+1. That is 2 cycles from wr_en to display.
- data_valid stays high for exactly HOLD_CYCLES cycles per code.
- Consecutive codes are spaced:
  - HOLD_CYCLES + GAP_CYCLES cycles apart when the FIFO is non-empty;
  - HOLD_CYCLES cycles apart when GAP_CYCLES = 0, with data_valid staying high continuously.
- level updates on the edge after a push or pop. overflow updates on the edge after a drop.

## Structure
- A shared package/include in PARAM holds:
  - state encodings (LMQ_IDLE = 2'd0, LMQ_SHOW = 2'd1, LMQ_GAP = 2'd2);
  - default WIDTH/DEPTH/HOLD/GAP values for the three LED-manager streams (UART data 8, UART error, VGA error).
- One sub-module is natural: lm_fifo. It owns the storage, pointers, level and the full/empty/drop logic, with push/pop handshake ports.
- The top level holds the FSM, the timer, the display register and the overflow flag.

## Test plan
All scenarios use WIDTH=4, DEPTH=4, HOLD_CYCLES=8, GAP_CYCLES=2 unless stated otherwise.
- Single push of 4'hA into an idle block: data_valid rises 2 cycles later, data_out = A for exactly 8 cycles, then 2 low cycles, then the FSM returns to IDLE and level = 0.
- Push 1,2,3 on consecutive cycles: the codes are shown in order 1, 2, 3, with data_valid rising edges 10 cycles apart and level peaking at 2.
- Push 6 codes back-to-back while the first is still being loaded: 5 codes are displayed (1 in the register plus 4 queued), the 6th is dropped, overflow = 1, and overflow stays 1 until overflow_clr.
- FIFO full during SHOW, with a push in the same cycle as the pop at GAP end: the push is accepted, overflow stays 0, and level stays 4.
- Repeat with GAP_CYCLES=0 and codes 5,5 queued: data_valid stays high for 16 continuous cycles, and data_out = 5 throughout.
- rst asserted mid-SHOW with level = 3: data_valid and level go to 0 immediately, and after release no stale code is ever shown.

Source files
------------

// File: rtl/lm_event_queue_pkg.sv
// Shared definitions for the LED-manager event queue: FSM state encodings,
// per-stream default configurations and a small sizing helper.
package lm_event_queue_pkg;

  typedef enum logic [1:0] {
    LMQ_IDLE = 2'd0,
    LMQ_SHOW = 2'd1,
    LMQ_GAP  = 2'd2
  } lmq_state_e;

  // UART received-data stream: full byte codes, one second visible.
  localparam int LMQ_UART_DATA_WIDTH = 8;
  localparam int LMQ_UART_DATA_DEPTH = 4;
  localparam int LMQ_UART_DATA_HOLD  = 50_000_000;
  localparam int LMQ_UART_DATA_GAP   = 5_000_000;

  // UART error stream: short error codes, rare, shown longer.
  localparam int LMQ_UART_ERR_WIDTH  = 4;
  localparam int LMQ_UART_ERR_DEPTH  = 2;
  localparam int LMQ_UART_ERR_HOLD   = 100_000_000;
  localparam int LMQ_UART_ERR_GAP    = 10_000_000;

  // CM/VGA error stream.
  localparam int LMQ_VGA_ERR_WIDTH   = 4;
  localparam int LMQ_VGA_ERR_DEPTH   = 2;
  localparam int LMQ_VGA_ERR_HOLD    = 100_000_000;
  localparam int LMQ_VGA_ERR_GAP     = 10_000_000;

  // Largest of three integers; used to size the shared hold/gap timer.
  function automatic int lmq_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lm_event_queue_if.sv
// Producer/decoder-side bundle of the event queue: enqueue strobe and code,
// overflow clear, and the displayed code/valid plus status back.
interface lm_event_queue_if
  import lm_event_queue_pkg::*;
#(
  parameter int WIDTH = LMQ_UART_DATA_WIDTH,
  parameter int DEPTH = LMQ_UART_DATA_DEPTH
);

  logic [WIDTH-1:0]       wr_data;
  logic                   wr_en;
  logic                   overflow_clr;
  logic [WIDTH-1:0]       data_out;
  logic                   data_valid;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;

  // Event source side.
  modport master (
    output wr_data, wr_en, overflow_clr,
    input  data_out, data_valid, overflow, level
  );

  // Queue side.
  modport slave (
    input  wr_data, wr_en, overflow_clr,
    output data_out, data_valid, overflow, level
  );

endinterface

// File: rtl/lm_fifo.sv
// Small circular FIFO for event codes. Owns storage, pointers and the entry
// count; a push is taken when there is room or when a pop frees a slot in the
// same cycle, otherwise it is dropped and reported on 'drop'.
module lm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             accept;

  assign accept   = push && ((level < LW'(DEPTH)) || pop);
  assign drop     = push && !accept;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lm_event_queue.sv
// Event queue in front of one LED-manager decoder input. Codes are buffered
// and each is shown for HOLD_CYCLES, followed by GAP_CYCLES blank cycles, so
// short or back-to-back events stay readable on the board.
module lm_event_queue
  import lm_event_queue_pkg::*;
#(
  parameter int WIDTH       = LMQ_UART_DATA_WIDTH,
  parameter int DEPTH       = LMQ_UART_DATA_DEPTH,
  parameter int HOLD_CYCLES = LMQ_UART_DATA_HOLD,
  parameter int GAP_CYCLES  = LMQ_UART_DATA_GAP
) (
  input logic             clk,
  input logic             rst,
  lm_event_queue_if.slave eq
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(lmq_max3(HOLD_CYCLES, GAP_CYCLES, 2));
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  lmq_state_e       state;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] disp;
  logic             disp_vld;
  logic             ovf;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [LW-1:0]    level;
  logic             drop;
  logic             not_empty;
  logic             timer_done;

  lm_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (eq.wr_en),
    .push_data (eq.wr_data),
    .pop       (pop),
    .pop_data  (head),
    .level     (level),
    .drop      (drop)
  );

  assign not_empty  = (level != '0);
  assign timer_done = (timer == '0);

  // Pop decision: idle with work pending, or end of a display slot
  // (gap end, or hold end when there is no gap) with work pending.
  always_comb begin
    pop = 1'b0;
    case (state)
      LMQ_IDLE: pop = not_empty;
      LMQ_SHOW: pop = timer_done && !HAS_GAP && not_empty;
      LMQ_GAP:  pop = timer_done && not_empty;
      default:  pop = 1'b0;
    endcase
  end

  // Display FSM: loads the head into the display register and times the
  // hold and gap phases with a single down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LMQ_IDLE;
      timer    <= '0;
      disp     <= '0;
      disp_vld <= 1'b0;
    end else begin
      case (state)
        LMQ_IDLE: begin
          if (pop) begin
            disp     <= head;
            timer    <= HOLD_LD;
            disp_vld <= 1'b1;
            state    <= LMQ_SHOW;
          end
        end
        LMQ_SHOW: begin
          if (!timer_done) begin
            timer <= timer - 1'b1;
          end else if (HAS_GAP) begin
            timer    <= GAP_LD;
            disp_vld <= 1'b0;
            state    <= LMQ_GAP;
          end else if (pop) begin
            // No gap: next code follows directly, valid stays high.
            disp  <= head;
            timer <= HOLD_LD;
          end else begin
            disp_vld <= 1'b0;
            state    <= LMQ_IDLE;
          end
        end
        LMQ_GAP: begin
          if (!timer_done) begin
            timer <= timer - 1'b1;
          end else if (pop) begin
            disp     <= head;
            timer    <= HOLD_LD;
            disp_vld <= 1'b1;
            state    <= LMQ_SHOW;
          end else begin
            state <= LMQ_IDLE;
          end
        end
        default: begin
          state    <= LMQ_IDLE;
          timer    <= '0;
          disp_vld <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ovf <= 1'b0;
    else if (drop)             ovf <= 1'b1;
    else if (eq.overflow_clr)  ovf <= 1'b0;
  end

  assign eq.data_out   = disp;
  assign eq.data_valid = disp_vld;
  assign eq.overflow   = ovf;
  assign eq.level      = level;

endmodule
